// File: rtl/latch_collector.sv
// latch_collector
//   Sink for a single-word out_vld/out_ack latch. Each word is acknowledged
//   only after the producer has held in_vld for ACK_DELAY cycles, which
//   models a slow consumer. Accepted words go into a small FWFT FIFO that is
//   drained on a valid/ready stream, and every accepted word is counted.
//
//   State | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no word pending; with ACK_DELAY=0 this state acks directly
//   WAIT  | in_vld seen, counting wcnt up towards ACK_DELAY
//   READY | delay satisfied; ack whenever the FIFO has room
//
// Ports
//   ap_clk      clock, rising edge
//   ap_rst      asynchronous active-high reset
//   in_vld      producer holds a word
//   in_data     producer word
//   in_ack      word accepted (transfer on edge with in_vld & in_ack)
//   dout_valid  FIFO head valid
//   dout_data   FIFO head word
//   dout_ready  downstream takes the head
//   level       FIFO occupancy
//   rx_count    words accepted since reset (wraps)
module latch_collector #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_vld,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ack,
    output logic                         dout_valid,
    output logic [DATA_W-1:0]            dout_data,
    input  logic                         dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [31:0]                  rx_count
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [7:0] DLY = 8'(ACK_DELAY);
    localparam bit ZERO_DLY = (ACK_DELAY == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_q;
    logic [31:0]       rx_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              full;
    logic              ack_window;
    logic              push;
    logic              pop;

    // Full is judged on the registered level only, so a pop in the same
    // cycle never opens the gate early and in_ack stays off dout_ready.
    assign full = (level_q == LW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        ack_window = (state_q == S_READY) || ((state_q == S_IDLE) && ZERO_DLY);
        in_ack     = !ap_rst && in_vld && !full && ack_window;

        if (!in_vld || in_ack) begin
            state_d = S_IDLE;
            wcnt_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ZERO_DLY) begin
                        // Only reached when full: park until room appears.
                        state_d = S_READY;
                    end else begin
                        wcnt_d  = 8'd1;
                        state_d = (DLY == 8'd1) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt_d = 8'(wcnt_q + 8'd1);
                    if (wcnt_d == DLY) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    state_d = S_READY;
                end
                default: begin
                    state_d = S_IDLE;
                    wcnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign push = in_ack;
    assign pop  = dout_valid && dout_ready;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            rx_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rx_q   <= rx_q + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read unless level says it was written.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign dout_valid = !ap_rst && (level_q != '0);
    assign dout_data  = dout_valid ? mem[rd_ptr] : '0;
    assign level      = level_q;
    assign rx_count   = rx_q;

endmodule
